trace_packetizer: RTL



---
 rtl/trace_packetizer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_packetizer.sv
// trace_packetizer
// ----------------
// Turns filtered RAM-bus events into typed trace packets and queues them in
// a first-word fall-through FIFO for the host side.
//
// Packet format: {type[1:0], payload[PW-1:0]}
//   00 address   : payload = filter_a (zero-extended)
//   10 write     : payload = {ts_field, ublb, filter_d}
//   01 read      : payload = {ts_field, ublb, nfilter_d}
//   11 timestamp : payload = full ts_counter (carries what ts_field clipped)
//
// Ports
//   mclk, reset_n                       clock, async active-low reset
//   trace_enable, trace_reads           master enable, read-packet enable
//   read_latency, write_latency         runtime burst latencies (bus clocks)
//   filter_*                            posedge bus-clock event + data/address
//   nfilter_d, nfilter_strobe           negedge bus-clock event + data
//   out_packet, out_valid, out_ready    FIFO head output stream
//   fifo_level                          FIFO occupancy 0..FIFO_DEPTH
//   overflow, overflow_clear            sticky drop flag and its clear
//   drop_count                          dropped packets (only counts when
//                                       TRACE_PACKETIZER_DROPCOUNT_EN is
//                                       defined, otherwise tied to 0)
//
// Handshake: out_packet is valid whenever out_valid is high; one packet is
// consumed on every rising mclk edge where out_valid && out_ready. out_valid
// never depends combinationally on out_ready.
module trace_packetizer #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int LAT_WIDTH  = 4,
  localparam int RW_W  = TS_WIDTH + 2 + DATA_WIDTH,
  localparam int PW    = (ADDR_WIDTH > RW_W) ? ADDR_WIDTH : RW_W,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic                  trace_enable,
  input  logic                  trace_reads,
  input  logic [LAT_WIDTH-1:0]  read_latency,
  input  logic [LAT_WIDTH-1:0]  write_latency,
  input  logic [ADDR_WIDTH-1:0] filter_a,
  input  logic [DATA_WIDTH-1:0] filter_d,
  input  logic [1:0]            filter_ublb,
  input  logic                  filter_read,
  input  logic                  filter_write,
  input  logic                  filter_addr_latch,
  input  logic                  filter_strobe,
  input  logic [DATA_WIDTH-1:0] nfilter_d,
  input  logic                  nfilter_strobe,
  output logic [PW+1:0]         out_packet,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] TS_ONE       = PW'(1);
  localparam logic [PW-1:0] TS_FIELD_MAX = PW'((1 << TS_WIDTH) - 1);

  logic [7:0]       burst_q, burst_d;
  logic [PW-1:0]    ts_q, ts_d, ts_inc, ts_field, ts_rem;
  logic             push;
  logic [PW+1:0]    push_pkt;
  logic [PW-1:0]    rw_payload_wr, rw_payload_rd;
  logic             strobe_en, addr_ev, wr_ev, rd_ev, ts_ev;

  logic [PW+1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             pop, full, accept, drop;

  // Timestamp helpers: the inline field clips at 2^TS_WIDTH-1 and the
  // remainder stays in the counter for a later timestamp packet.
  always_comb begin
    ts_inc   = (ts_q == {PW{1'b1}}) ? ts_q : ts_q + TS_ONE;
    ts_field = (ts_q > TS_FIELD_MAX) ? TS_FIELD_MAX : ts_q;
    ts_rem   = ts_q - ts_field;
  end

  // Burst cycle number of the current bus cycle: 0 on the address latch,
  // then 1, 2, ... on each read/write posedge strobe.
  always_comb begin
    burst_d = burst_q;
    if (trace_enable && filter_strobe) begin
      if (filter_addr_latch)
        burst_d = 8'd0;
      else if ((filter_read || filter_write) && burst_q != 8'hFF)
        burst_d = burst_q + 8'd1;
    end
  end

  // A write strobe is judged on the cycle number it advances to; a negedge
  // read sample belongs to the cycle whose posedge already advanced burst_q.
  assign strobe_en = trace_enable && filter_strobe;
  assign addr_ev   = strobe_en && filter_addr_latch;
  assign wr_ev     = strobe_en && filter_write &&
                     ((32'(burst_d) + 32'd1) >= 32'(write_latency));
  assign rd_ev     = trace_enable && trace_reads && nfilter_strobe && filter_read &&
                     (32'(burst_q) >= 32'(read_latency));
  assign ts_ev     = strobe_en && (burst_d == 8'd1) && (ts_rem != '0);

  always_comb begin
    rw_payload_wr = '0;
    rw_payload_wr[RW_W-1:0] = {ts_field[TS_WIDTH-1:0], filter_ublb, filter_d};
    rw_payload_rd = '0;
    rw_payload_rd[RW_W-1:0] = {ts_field[TS_WIDTH-1:0], filter_ublb, nfilter_d};
  end

  // Single push per cycle, highest-priority event wins.
  always_comb begin
    push     = 1'b0;
    push_pkt = '0;
    ts_d     = ts_q;
    if (addr_ev) begin
      push = 1'b1;
      push_pkt[ADDR_WIDTH-1:0] = filter_a;
      ts_d = ts_inc;
    end else if (wr_ev) begin
      push     = 1'b1;
      push_pkt = {2'b10, rw_payload_wr};
      ts_d     = ts_rem;
    end else if (rd_ev) begin
      push     = 1'b1;
      push_pkt = {2'b01, rw_payload_rd};
      ts_d     = ts_rem;
    end else if (ts_ev) begin
      push     = 1'b1;
      push_pkt = {2'b11, ts_q};
      ts_d     = '0;
    end else if (strobe_en) begin
      ts_d = ts_inc;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push to a
  // full FIFO, so only push-while-full-without-pop drops.
  assign full   = (count_q == LVL_W'(FIFO_DEPTH));
  assign pop    = (count_q != '0) && out_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      burst_q    <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      burst_q <= burst_d;
      ts_q    <= ts_d;
      count_q <= count_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= push_pkt;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                overflow_q <= 1'b1;
      else if (overflow_clear) overflow_q <= 1'b0;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_packet = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
  assign overflow   = overflow_q;

`ifdef TRACE_PACKETIZER_DROPCOUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt_q <= 16'h0000;
    else if (overflow_clear)
      drop_cnt_q <= drop ? 16'h0001 : 16'h0000;
    else if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'h0001;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule
